uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB-first assembly, one-cycle valid strobe,
// running byte sum and sticky framing-error flag. Line is already in this clock domain.
module uart_rx #(
  parameter int cycles_per_bit = 4
) (
  input  logic        clock,
  input  logic        tick_reset,
  input  logic        tick_serial,
  output logic        get_valid_ret,
  output logic [7:0]  get_buffer_ret,
  output logic [31:0] get_sum_ret,
  output logic        get_error_ret
);

  localparam int half_bit = cycles_per_bit / 2;
  localparam int phase_w  = $clog2(cycles_per_bit);
  localparam logic [phase_w-1:0] phase_last  = phase_w'(cycles_per_bit - 1);
  // Preload so the start-bit sample lands half_bit cycles after the falling edge.
  localparam logic [phase_w-1:0] phase_start = phase_w'(cycles_per_bit - half_bit);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t              state_r, state_next_s;
  logic [phase_w-1:0]  phase_r, phase_next_s;
  logic [3:0]          bit_idx_r, bit_idx_next_s;
  logic [7:0]          shift_r, shift_next_s;
  logic                frame_good_s, frame_bad_s, sample_s;
  logic                valid_r, error_r;
  logic [7:0]          buffer_r;
  logic [31:0]         sum_r;

  assign sample_s       = (phase_r == phase_last);
  assign get_valid_ret  = valid_r;
  assign get_buffer_ret = buffer_r;
  assign get_sum_ret    = sum_r;
  assign get_error_ret  = error_r;

  // Next-state and datapath control decode.
  always_comb begin
    state_next_s   = state_r;
    phase_next_s   = phase_r;
    bit_idx_next_s = bit_idx_r;
    shift_next_s   = shift_r;
    frame_good_s   = 1'b0;
    frame_bad_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!tick_serial) begin
          state_next_s   = ST_START;
          phase_next_s   = phase_start;
          bit_idx_next_s = 4'd0;
        end else begin
          phase_next_s   = '0;
        end
      end
      ST_START: begin
        if (sample_s) begin
          phase_next_s = '0;
          if (tick_serial) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          phase_next_s = phase_r + phase_w'(1);
        end
      end
      ST_DATA: begin
        if (sample_s) begin
          phase_next_s   = '0;
          shift_next_s   = {tick_serial, shift_r[7:1]};
          bit_idx_next_s = bit_idx_r + 4'd1;
          if (bit_idx_r == 4'd7) begin
            state_next_s = ST_STOP;
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          phase_next_s = phase_r + phase_w'(1);
        end
      end
      ST_STOP: begin
        if (sample_s) begin
          phase_next_s = '0;
          if (tick_serial) begin
            frame_good_s = 1'b1;
            state_next_s = ST_IDLE;
          end else begin
            frame_bad_s  = 1'b1;
            state_next_s = ST_BREAK;
          end
        end else begin
          phase_next_s = phase_r + phase_w'(1);
        end
      end
      // Hold here while the line stays low so a break is not decoded as 0x00 frames.
      ST_BREAK: begin
        if (tick_serial) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BREAK;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        phase_next_s = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (tick_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Counters, shift register and registered outputs.
  always_ff @(posedge clock) begin
    if (tick_reset) begin
      phase_r   <= '0;
      bit_idx_r <= 4'd0;
      shift_r   <= 8'h00;
      valid_r   <= 1'b0;
      buffer_r  <= 8'h00;
      sum_r     <= 32'h0000_0000;
      error_r   <= 1'b0;
    end else begin
      phase_r   <= phase_next_s;
      bit_idx_r <= bit_idx_next_s;
      shift_r   <= shift_next_s;
      valid_r   <= frame_good_s;
      if (frame_good_s) begin
        buffer_r <= shift_r;
        sum_r    <= sum_r + {24'h00_0000, shift_r};
      end else begin
        buffer_r <= buffer_r;
        sum_r    <= sum_r;
      end
      if (frame_bad_s) begin
        error_r <= 1'b1;
      end else begin
        error_r <= error_r;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand sequences and random frames
// scored against a frame-level reference model (expected event times from bit timing).
module tb_uart_rx;

  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;
  localparam int LAT  = HALF + 9 * CPB + 1;

  logic        clock;
  logic        tick_reset;
  logic        tick_serial;
  logic        get_valid_ret;
  logic [7:0]  get_buffer_ret;
  logic [31:0] get_sum_ret;
  logic        get_error_ret;

  uart_rx #(.cycles_per_bit(CPB)) dut (
    .clock          (clock),
    .tick_reset     (tick_reset),
    .tick_serial    (tick_serial),
    .get_valid_ret  (get_valid_ret),
    .get_buffer_ret (get_buffer_ret),
    .get_sum_ret    (get_sum_ret),
    .get_error_ret  (get_error_ret)
  );

  typedef struct {
    int         at;
    logic [7:0] data;
    logic       good;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic        stop_ok;
    int          hold_low;
    int          gap;
    logic [7:0]  exp_buf;
    logic [31:0] exp_sum;
    logic        exp_err;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[4];
  int          cyc_cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          vcount = 0;
  bit          mon_on = 1'b0;
  logic [7:0]  m_buf = 8'h00;
  logic [31:0] m_sum = 32'h0;
  logic        m_err = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Reference monitor: expected outputs derived from the frames the driver sent.
  initial begin
    exp_t ev;
    logic exp_v;
    forever begin
      @(negedge clock);
      if (mon_on) begin
        exp_v = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].at == cyc_cnt) begin
          ev = exp_q.pop_front();
          if (ev.good) begin
            exp_v = 1'b1;
            m_buf = ev.data;
            m_sum = m_sum + {24'h0, ev.data};
          end else begin
            m_err = 1'b1;
          end
        end
        check("mon_valid",  {31'h0, get_valid_ret}, {31'h0, exp_v});
        check("mon_buffer", {24'h0, get_buffer_ret}, {24'h0, m_buf});
        check("mon_sum",    get_sum_ret, m_sum);
        check("mon_error",  {31'h0, get_error_ret}, {31'h0, m_err});
        if (get_valid_ret === 1'b1) vcount++;
      end
      if (tick_reset) begin
        m_buf = 8'h00;
        m_sum = 32'h0;
        m_err = 1'b0;
        exp_q.delete();
      end
    end
  end

  task automatic step(input logic s);
    tick_serial = s;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    tick_reset = 1'b1;
    step(1'b1);
    tick_reset = 1'b0;
  endtask

  // Drives one 8N1 frame; abort_at >= 0 pulses reset at that offset instead of finishing.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int abort_at);
    logic v;
    exp_t e;
    for (int off = 0; off < 10 * CPB; off++) begin
      if (off == abort_at) begin
        do_reset();
        return;
      end
      if (off == 0) begin
        e.at   = cyc_cnt + LAT;
        e.data = b;
        e.good = stop_ok;
        exp_q.push_back(e);
      end
      if (off < CPB) v = 1'b0;
      else if (off < 9 * CPB) v = b[off / CPB - 1];
      else v = stop_ok;
      step(v);
    end
  endtask

  task automatic check_outs(input string name, input logic [7:0] b, input logic [31:0] s,
                            input logic e);
    check({name, "_buffer"}, {24'h0, get_buffer_ret}, {24'h0, b});
    check({name, "_sum"}, get_sum_ret, s);
    check({name, "_error"}, {31'h0, get_error_ret}, {31'h0, e});
  endtask

  initial begin
    int r;
    vecs[0] = '{8'h55, 1'b1, 0, 0, 8'h55, 32'h0000_0055, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 0, 0, 8'hA3, 32'h0000_00F8, 1'b0};
    vecs[2] = '{8'h81, 1'b0, 30, 2, 8'hA3, 32'h0000_00F8, 1'b1};
    vecs[3] = '{8'h01, 1'b1, 0, 2, 8'h01, 32'h0000_00F9, 1'b1};

    tick_reset  = 1'b1;
    tick_serial = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    tick_reset = 1'b0;
    mon_on = 1'b1;
    check("reset_valid", {31'h0, get_valid_ret}, 32'h0);
    check_outs("reset", 8'h00, 32'h0, 1'b0);
    step(1'b1);

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_ok, -1);
      repeat (vecs[i].hold_low) step(1'b0);
      repeat (vecs[i].gap) step(1'b1);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_buf, vecs[i].exp_sum, vecs[i].exp_err);
    end

    // Single-cycle glitch is a false start; the following frame must still decode.
    step(1'b0);
    repeat (3) step(1'b1);
    check_outs("glitch", 8'h01, 32'h0000_00F9, 1'b1);
    send_frame(8'h3C, 1'b1, -1);
    repeat (2) step(1'b1);
    check_outs("after_glitch", 8'h3C, 32'h0000_0135, 1'b1);

    // Reset mid-frame abandons the frame; the next one is received from scratch.
    send_frame(8'h99, 1'b1, 20);
    check("midreset_valid", {31'h0, get_valid_ret}, 32'h0);
    check_outs("midreset", 8'h00, 32'h0, 1'b0);
    step(1'b1);
    send_frame(8'h7E, 1'b1, -1);
    repeat (2) step(1'b1);
    check_outs("after_reset", 8'h7E, 32'h0000_007E, 1'b0);

    // Loopback-style stream 0x00..0xFF with no idle gaps.
    do_reset();
    step(1'b1);
    vcount = 0;
    for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1, -1);
    repeat (2) step(1'b1);
    check("loop_count", 32'(vcount), 32'd256);
    check_outs("loop", 8'hFF, 32'h0000_7F80, 1'b0);

    // Randomized mix of good frames, framing errors, glitches and aborts.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin
        step(1'b0);
        repeat (2 + $urandom_range(0, 2)) step(1'b1);
      end else if (r == 1) begin
        send_frame(8'($urandom), 1'b0, -1);
        repeat ($urandom_range(0, 10)) step(1'b0);
        repeat (1 + $urandom_range(0, 3)) step(1'b1);
      end else if (r == 2) begin
        send_frame(8'($urandom), 1'b1, $urandom_range(1, 38));
      end else begin
        send_frame(8'($urandom), 1'b1, -1);
        repeat ($urandom_range(0, 3)) step(1'b1);
      end
    end
    repeat (3) step(1'b1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
